// File: rtl/demux16_deser.sv
// demux16_deser: bit-serial to 16-bit parallel collector.
// Steers each accepted bit into an accumulator and emits framed words.
module demux16_deser #(
    parameter bit LSB_FIRST      = 1'b1,
    parameter bit CLEAR_ON_FRAME = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    input  logic [3:0]  in_sel,
    input  logic        addr_mode,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [4:0]  out_count
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] STALL   = 1'b1;

    logic [0:0]  state;
    logic [15:0] acc;
    logic [4:0]  cnt;
    logic [4:0]  held_count;

    logic        accept;
    logic        consume;
    logic        complete;
    logic [3:0]  auto_pos;
    logic [3:0]  pos;
    logic [4:0]  cnt_next;
    logic [15:0] merged;
    logic [15:0] acc_after_frame;
    logic [15:0] acc_after_release;

    assign in_ready = rst_n & (state == COLLECT);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    // Target position and the accumulator with the incoming bit merged in
    always_comb begin
        auto_pos = LSB_FIRST ? cnt[3:0] : (4'd15 - cnt[3:0]);
        pos      = addr_mode ? in_sel : auto_pos;
        cnt_next = cnt + 5'd1;
        merged      = acc;
        merged[pos] = in_bit;
        complete    = accept & (in_last | (cnt_next == 5'd16));
        acc_after_frame   = CLEAR_ON_FRAME ? 16'h0000 : merged;
        acc_after_release = CLEAR_ON_FRAME ? 16'h0000 : acc;
    end

    // Frame assembly, output register load and stall handling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            acc        <= 16'h0000;
            cnt        <= 5'd0;
            held_count <= 5'd0;
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            out_count  <= 5'd0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (consume) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (complete) begin
                            cnt <= 5'd0;
                            if (!out_valid || consume) begin
                                out_data  <= merged;
                                out_count <= cnt_next;
                                out_valid <= 1'b1;
                                acc       <= acc_after_frame;
                            end else begin
                                // Output slot busy: park the word in acc
                                acc        <= merged;
                                held_count <= cnt_next;
                                state      <= STALL;
                            end
                        end else begin
                            acc <= merged;
                            cnt <= cnt_next;
                        end
                    end
                end
                STALL: begin
                    // out_valid is already 1 here and stays 1
                    if (consume) begin
                        out_data  <= acc;
                        out_count <= held_count;
                        acc       <= acc_after_release;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/demux16_deser.md
Name: demux16_deser

Overview:
Serial-to-parallel collector, the inverse of the 16:1 bit multiplexer used in the ALU datapath. It accepts one bit per handshake and steers each bit into one of 16 positions of an accumulator. Positions come from an internal index counter or from an explicit 4-bit select. When a frame completes, it presents the assembled 16-bit word on a valid/ready output port. It feeds the 16-bit ALU operand registers from a 1-bit serial source.

Parameters:
LSB_FIRST, 1, auto mode: 1 = first bit lands in position 0; 0 = first bit lands in position 15
CLEAR_ON_FRAME, 1, 1 = accumulator zeroed at frame start (unwritten positions read 0); 0 = unwritten positions retain the prior frame's bits

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  in_bit/in_sel/in_last/addr_mode valid this cycle
in_ready  output  1  block can accept a bit
in_bit  input  1  serial data bit
in_sel  input  4  target position when addr_mode=1
addr_mode  input  1  0 = auto index, 1 = use in_sel; sampled per accepted bit
in_last  input  1  accepted bit ends the frame early
out_valid  output  1  out_data/out_count hold a completed word
out_ready  input  1  consumer takes the word
out_data  output  16  assembled word
out_count  output  5  accepted bits in the frame, 1..16

Behaviour:
- Accept = in_valid & in_ready at the rising edge. Consume = out_valid & out_ready at the rising edge.
- Reset (rst_n low at edge): out_valid=0, out_data=0, out_count=0, accumulator=0, bit count=0, state=COLLECT. in_ready is forced 0 while rst_n is low. Reset mid-frame discards the partial frame and any held or stalled word.
- Internal: acc[15:0], cnt[4:0] (bits accepted this frame), state in {COLLECT, STALL}. in_ready = rst_n & (state==COLLECT).
- Position on accept:
  - addr_mode=0: pos = cnt[3:0] if LSB_FIRST, else 15-cnt[3:0].
  - addr_mode=1: pos = in_sel.
  - cnt increments on every accept regardless of mode. Mixed modes within a frame are legal.
  - A repeated write to the same position: last write wins.
- Frame completion: an accept with in_last=1, or the accept that makes cnt reach 16. The completing word is acc with the new bit merged in; its count is cnt+1.
- On completion in COLLECT:
  - If out_valid=0, or a consume happens the same edge: load out_data/out_count, out_valid=1 (stays 1 across a same-edge consume). Latency is one edge: the word is visible the cycle after the completing accept. Clear acc (per CLEAR_ON_FRAME) and cnt=0; the next bit may be accepted the very next cycle.
  - Otherwise: keep the completed word in acc, cnt=0, go to STALL (in_ready=0).
- STALL: on consume, load the held word into out_data/out_count, keep out_valid=1, clear acc, go to COLLECT. in_ready rises the following cycle.
- Consume with no new word pending: out_valid=0. out_data/out_count keep their last value.
- out_data/out_count change only on load or reset. They are stable while out_valid=1 and out_ready=0.
- An in_last on the 16th bit is a single completion. There is no empty frame.
- Inputs are ignored when not accepted. No overrun is possible: backpressure is through in_ready.
- Fully synchronous. No combinational path from in_valid to in_ready. out_ready affects in_ready only via registered state.

Test Plan:
- Auto, LSB_FIRST=1, out_ready=1: send 16 bits of 0xA5C3, LSB first -> out_valid pulses one cycle after the 16th accept; out_data=0xA5C3, out_count=16; in_ready stays 1 throughout.
- Early end: bits 1,0,1,1,1 with in_last on the 5th -> out_data=0x001D, out_count=5. The next frame starts at position 0: a single bit 1 with in_last gives 0x0001, count 1.
- Addressed: (bit1, sel15), (bit1, sel3), (bit1, sel0, in_last) -> out_data=0x8009, out_count=3. The same frame with sel3 rewritten with 0 before in_last -> 0x8001.
- Backpressure: out_ready=0; complete frame A=0x1234, then frame B=0xBEEF -> state STALL, in_ready=0, out_data stays 0x1234. Raise out_ready for one cycle -> next cycle out_data=0xBEEF, out_valid=1, in_ready=1.
- Simultaneous: out_valid=1 holding 0x00FF, out_ready=1 on the same edge as frame 0xF0F0 completes -> out_valid never drops; out_data=0xF0F0 next cycle; no STALL entered.
- Reset mid-operation: 7 bits accepted plus a word held with out_ready=0, then rst_n=0 for one edge -> out_valid=0, out_data=0, out_count=0, in_ready=0 during reset. The next 16-bit auto frame 0x5555 is reassembled correctly from position 0.
